// File: rtl/gpio_periph_if.sv
// rtl/gpio_periph_if.sv - native valid/ready memory bus between CPU and gpio_periph
interface gpio_periph_if;
   logic        mem_valid;
   logic [4:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/gpio_periph.sv
// rtl/gpio_periph.sv - 8-bit GPIO: OUT with set/clr/tog aliases, synced IN, sticky edge capture, level irq
module gpio_periph #(
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            resetn,
   gpio_periph_if.slave    bus,
   input  logic [7:0]      gpio_pin_in,
   output logic [7:0]      gpio_pin_out,
   output logic            irq
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_t;

   state_t                          state_q, state_d;
   logic [7:0]                      out_q, out_d;
   logic [7:0]                      ie_q, ie_d;
   logic [7:0]                      rise_q, rise_d;
   logic [7:0]                      fall_q, fall_d;
   logic [7:0]                      rdata_q, rdata_d;
   logic [7:0]                      p_q, p_d;
   logic [SYNC_STAGES-1:0][7:0]     sync_q, sync_d;

   logic [7:0] s;
   logic [7:0] edge_rise, edge_fall;
   logic [7:0] rise_clr, fall_clr;
   logic [7:0] wdata;
   logic       access, wr_en;
   logic       unused_bus_bits;

   assign unused_bus_bits = ^{bus.mem_wdata[31:8], bus.mem_addr[1:0], bus.mem_wstrb[3:1]};

   assign s         = sync_q[SYNC_STAGES-1];
   assign edge_rise = s & ~p_q;
   assign edge_fall = ~s & p_q;
   assign wdata     = bus.mem_wdata[7:0];
   assign access    = (state_q == ST_IDLE) && bus.mem_valid;
   assign wr_en     = access && bus.mem_wstrb[0];

   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      ie_d     = ie_q;
      rdata_d  = 8'h00;
      rise_clr = 8'h00;
      fall_clr = 8'h00;
      sync_d   = sync_q;
      p_d      = s;

      sync_d[0] = gpio_pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end

      case (state_q)
         ST_IDLE: if (bus.mem_valid) state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Read data reflects register values from before this edge's update.
      if (access) begin
         case (bus.mem_addr[4:2])
            3'd0:    rdata_d = out_q;
            3'd1:    rdata_d = s;
            3'd5:    rdata_d = rise_q;
            3'd6:    rdata_d = fall_q;
            3'd7:    rdata_d = ie_q;
            default: rdata_d = 8'h00;
         endcase
      end

      if (wr_en) begin
         case (bus.mem_addr[4:2])
            3'd0:    out_d    = wdata;
            3'd2:    out_d    = out_q | wdata;
            3'd3:    out_d    = out_q & ~wdata;
            3'd4:    out_d    = out_q ^ wdata;
            3'd5:    rise_clr = wdata;
            3'd6:    fall_clr = wdata;
            3'd7:    ie_d     = wdata;
            default: ;
         endcase
      end

      // A fresh edge in the same cycle as a clearing write keeps the bit set.
      rise_d = (rise_q & ~rise_clr) | edge_rise;
      fall_d = (fall_q & ~fall_clr) | edge_fall;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         out_q   <= 8'h00;
         ie_q    <= 8'h00;
         rise_q  <= 8'h00;
         fall_q  <= 8'h00;
         rdata_q <= 8'h00;
         p_q     <= 8'h00;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         ie_q    <= ie_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         rdata_q <= rdata_d;
         p_q     <= p_d;
         sync_q  <= sync_d;
      end
   end

   // Reset asserted in the ACK cycle suppresses the pending response.
   assign bus.mem_ready = (state_q == ST_ACK) && resetn;
   assign bus.mem_rdata = bus.mem_ready ? {24'h000000, rdata_q} : 32'h0000_0000;
   assign gpio_pin_out  = out_q;
   assign irq           = |((rise_q | fall_q) & ie_q);

endmodule

// File: tb/tb_gpio_periph.sv
// tb/tb_gpio_periph.sv - randomized scoreboard bench for gpio_periph
module tb_gpio_periph;
   localparam int S = 2;
   localparam logic [4:0] A_OUT = 5'h00, A_IN = 5'h04, A_SET = 5'h08, A_CLR = 5'h0C;
   localparam logic [4:0] A_TOG = 5'h10, A_RISE = 5'h14, A_FALL = 5'h18, A_IE = 5'h1C;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] pin_in = 8'h00;
   logic [7:0] pin_out;
   logic       irq;

   gpio_periph_if bus();

   gpio_periph #(.SYNC_STAGES(S)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .bus          (bus),
      .gpio_pin_in  (pin_in),
      .gpio_pin_out (pin_out),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ready_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pin history per edge plus register image.
   logic [7:0] pin_at [0:16383];
   logic [7:0] m_out = 8'h00, m_ie = 8'h00, m_rise = 8'h00, m_fall = 8'h00;
   bit         m_ack = 1'b0;
   int         cyc = 0;
   logic [7:0] rq [$];

   function automatic logic [7:0] ph(input int k);
      return (k < 0) ? 8'h00 : pin_at[k];
   endfunction

   logic [7:0] mv_s, mv_p, mv_er, mv_ef, mv_w, mv_rd, mv_cr, mv_cf;

   always @(posedge clk) begin
      pin_at[cyc] = pin_in;
      if (!resetn) begin
         m_out = 0; m_ie = 0; m_rise = 0; m_fall = 0; m_ack = 0;
      end else begin
         mv_s  = ph(cyc - S);
         mv_p  = ph(cyc - S - 1);
         mv_er = mv_s & ~mv_p;
         mv_ef = ~mv_s & mv_p;
         mv_cr = 0;
         mv_cf = 0;
         if (!m_ack && bus.mem_valid) begin
            mv_w = bus.mem_wdata[7:0];
            case (bus.mem_addr[4:2])
               3'd0: mv_rd = m_out;
               3'd1: mv_rd = mv_s;
               3'd5: mv_rd = m_rise;
               3'd6: mv_rd = m_fall;
               3'd7: mv_rd = m_ie;
               default: mv_rd = 0;
            endcase
            rq.push_back(mv_rd);
            if (bus.mem_wstrb[0]) begin
               case (bus.mem_addr[4:2])
                  3'd0: m_out = mv_w;
                  3'd2: m_out = m_out | mv_w;
                  3'd3: m_out = m_out & ~mv_w;
                  3'd4: m_out = m_out ^ mv_w;
                  3'd5: mv_cr = mv_w;
                  3'd6: mv_cf = mv_w;
                  3'd7: m_ie  = mv_w;
                  default: ;
               endcase
            end
            m_ack = 1;
         end else begin
            m_ack = 0;
         end
         m_rise = (m_rise & ~mv_cr) | mv_er;
         m_fall = (m_fall & ~mv_cf) | mv_ef;
      end
      cyc++;
   end

   // Monitor: compares outputs every cycle and pops responses on mem_ready.
   logic [7:0] mon_e;
   bit         mon_exp_ready;
   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("gpio_pin_out", {24'h0, pin_out}, {24'h0, m_out});
         chk("irq", {31'h0, irq}, {31'h0, |((m_rise | m_fall) & m_ie)});
         mon_exp_ready = m_ack && resetn;
         mon_e = 0;
         if (m_ack && rq.size() > 0) mon_e = rq.pop_front();
         chk("mem_ready", {31'h0, bus.mem_ready}, {31'h0, mon_exp_ready});
         if (bus.mem_ready) begin
            ready_cnt++;
            if (mon_exp_ready) chk("mem_rdata", bus.mem_rdata, {24'h0, mon_e});
         end else begin
            chk("mem_rdata_idle", bus.mem_rdata, 32'h0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      if (n > 0) #1;
   endtask

   task automatic access(input logic [4:0] a, input logic [7:0] d, input logic [3:0] st,
                         output logic [31:0] rd);
      logic [31:0] w;
      bit          got;
      w = $urandom();
      w[7:0] = d;
      bus.mem_addr  = {a[4:2], 2'($urandom_range(0, 3))};
      bus.mem_wdata = w;
      bus.mem_wstrb = st;
      bus.mem_valid = 1'b1;
      got = 0;
      rd = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         if (bus.mem_ready) begin
            got = 1;
            rd = bus.mem_rdata;
         end
      end
      if (!got) chk("handshake_timeout", 32'h0, 32'h1);
      @(posedge clk);
      #1 bus.mem_valid = 1'b0;
   endtask

   logic [31:0] rd;
   int          c0;

   initial begin
      bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_wdata = 0; bus.mem_wstrb = 0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      idle(2);
      chk("reset_out", {24'h0, pin_out}, 32'h0);
      chk("reset_irq", {31'h0, irq}, 32'h0);
      access(A_IN, 8'h00, 4'h0, rd);
      chk("reset_in_read", rd, 32'h0);

      access(A_OUT, 8'h0F, 4'h1, rd); chk("seq_out", {24'h0, pin_out}, 32'h0F);
      access(A_SET, 8'hF0, 4'h1, rd); chk("seq_set", {24'h0, pin_out}, 32'hFF);
      access(A_CLR, 8'h03, 4'h1, rd); chk("seq_clr", {24'h0, pin_out}, 32'hFC);
      access(A_TOG, 8'h81, 4'h1, rd); chk("seq_tog", {24'h0, pin_out}, 32'h7D);

      pin_in = 8'h05; idle(4);
      pin_in = 8'h00; idle(6);
      access(A_IE, 8'h01, 4'hF, rd);
      chk("irq_set", {31'h0, irq}, 32'h1);
      access(A_RISE, 8'h00, 4'h0, rd); chk("rise_05", rd, 32'h05);
      access(A_FALL, 8'h00, 4'h0, rd); chk("fall_05", rd, 32'h05);
      access(A_RISE, 8'h01, 4'h1, rd);
      access(A_FALL, 8'h01, 4'h1, rd);
      chk("irq_clear", {31'h0, irq}, 32'h0);
      access(A_RISE, 8'h00, 4'h0, rd); chk("rise_after_w1c", rd, 32'h04);

      pin_in = 8'h02; idle(4);
      pin_in = 8'h00; idle(4);
      pin_in = 8'h02; idle(2);
      access(A_RISE, 8'h02, 4'h1, rd);
      access(A_RISE, 8'h00, 4'h0, rd); chk("rise1_kept", {31'h0, rd[1]}, 32'h1);

      bus.mem_addr = A_IN; bus.mem_wstrb = 4'h0; bus.mem_valid = 1'b1;
      c0 = ready_cnt;
      repeat (6) @(posedge clk);
      #1 bus.mem_valid = 1'b0;
      idle(2);
      chk("burst_ready_cnt", ready_cnt - c0, 32'd3);

      access(A_OUT, 8'h55, 4'b0010, rd);
      chk("wstrb_noop", {24'h0, pin_out}, 32'h7D);

      fork
         begin
            repeat (200) begin
               pin_in = 8'($urandom());
               idle($urandom_range(1, 3));
            end
         end
         begin
            repeat (60) begin
               access(5'($urandom_range(0, 7) * 4), 8'($urandom()), 4'($urandom()), rd);
               idle($urandom_range(0, 2));
            end
         end
      join

      pin_in = 8'h00; idle(6);
      bus.mem_addr = A_OUT; bus.mem_wdata = 32'hAA; bus.mem_wstrb = 4'h1; bus.mem_valid = 1'b1;
      @(posedge clk);
      #1 resetn = 1'b0; bus.mem_valid = 1'b0;
      @(negedge clk);
      chk("ready_suppressed", {31'h0, bus.mem_ready}, 32'h0);
      chk("out_before_reset", {24'h0, pin_out}, 32'hAA);
      @(posedge clk);
      #1 resetn = 1'b1;
      chk("out_after_reset", {24'h0, pin_out}, 32'h0);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL global_timeout actual=%0t required=<200000", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/gpio_periph.md
# gpio_periph

Memory-mapped 8-bit GPIO peripheral for the example SoCs. It drives `gpio_pin_out` and samples `gpio_pin_in`, the two buses the common testbench uses to stimulate the design and detect completion (`gpio_pin_out == 8'hff`). The CPU reaches the peripheral over the native valid/ready memory interface. The block provides:
- an output register with set/clear/toggle aliases;
- a synchronized input view;
- sticky edge-capture registers;
- a level interrupt.

## Interface
- `SYNC_STAGES`, 2, number of input synchronizer flops (≥2).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `mem_valid`  in  1  request valid; held by requester until `mem_ready`.
- `mem_addr`  in  5  byte offset; bits [1:0] ignored.
- `mem_wdata`  in  32  write data; only [7:0] used.
- `mem_wstrb`  in  4  byte strobes; 0 = read.
- `mem_ready`  out  1  one-cycle response pulse.
- `mem_rdata`  out  32  read data; [31:8] always 0; 0 when `mem_ready` low.
- `gpio_pin_in`  in  8  asynchronous external inputs.
- `gpio_pin_out`  out  8  output register contents.
- `irq`  out  1  level interrupt.

## Operation
- Register map (word offsets):
  - 0x00 OUT rw.
  - 0x04 IN ro (synchronized pins).
  - 0x08 SET wo: OUT |= wdata.
  - 0x0C CLR wo: OUT &= ~wdata.
  - 0x10 TOG wo: OUT ^= wdata.
  - 0x14 RISE rw1c.
  - 0x18 FALL rw1c.
  - 0x1C IE rw.
  - Reads of the wo aliases (0x08–0x10) return 0.
  - Unmapped offsets (0x1C–0x1F handled above; none remain in 5 bits besides these) read 0, ignore writes, and are still acknowledged.
- Write effective only when `mem_wstrb[0]` = 1.
  - A nonzero strobe with `mem_wstrb[0]` = 0 is a no-op write, acknowledged normally.
- Handshake FSM, two states:
  - IDLE: `mem_valid` = 1 → perform access at this edge, go to ACK.
  - ACK: `mem_ready` = 1 for exactly this cycle; unconditionally return to IDLE.
  - `mem_valid` is ignored while in ACK, so one request produces exactly one access.
- Input path:
  - `gpio_pin_in` passes through a `SYNC_STAGES` flop chain to `s`; `p` is `s` delayed one cycle.
  - `rise = s & ~p`, `fall = ~s & p`.
- Edge capture per bit:
  - RISE_next = (RISE & ~w1c_mask) | rise; FALL likewise.
  - A new edge in the same cycle as a clearing write wins: the bit stays set.
- `irq = |((RISE | FALL) & IE)`, derived from registers only (no combinational path from inputs).
- Reset (`resetn` low at a rising edge):
  - OUT, IE, RISE, FALL, the sync chain and `p` all clear to 0.
  - FSM goes to IDLE; `mem_ready` = 0, `mem_rdata` = 0, `gpio_pin_out` = 0, `irq` = 0.
  - A pin held high across reset release produces one RISE event after synchronization. This is intended.
- Reset during ACK: the ready pulse is suppressed and the register side effect already taken stands. Reset while a request is in IDLE: no access is performed.

## Timing
- Request sampled at edge N:
  - `mem_ready` and `mem_rdata` are valid in cycle N..N+1 (latency 1).
  - Write side effects are visible on `gpio_pin_out` from the same edge N.
- Throughput: one access per 2 cycles.
  - Requester may present the next request in the cycle after `mem_ready`; it is accepted at the following edge.
- Pin change sampled at edge K:
  - IN reflects it from edge K+SYNC_STAGES-1.
  - RISE/FALL set at edge K+SYNC_STAGES.
  - `irq` rises in the same cycle as the RISE/FALL bit.
- Read data is the register value before the current edge's update.
  - A RISE read returns a bit whose setting edge precedes the access edge.
- Pulses shorter than one clock may be missed.
  - Pulses ≥2 clocks always produce one RISE and one FALL event.

## Test plan
- Reset with `gpio_pin_in` = 8'h00 → all outputs 0; read IN → 0, `mem_ready` high exactly one cycle after `mem_valid`.
- Write OUT = 8'h0F, SET 8'hF0, CLR 8'h03, TOG 8'h81 → `gpio_pin_out` sequence 0x0F, 0xFF, 0xFC, 0x7D; the write of SET drives 0xFF, which must trip the testbench finish check.
- `gpio_pin_in` 8'h00 → 8'h05 held 4 cycles, then 8'h00 → RISE = 0x05 at K+2, FALL = 0x05 later; with IE = 0x01, `irq` = 1; W1C RISE 0x01 and FALL 0x01 → `irq` = 0, RISE = 0x04.
- Clearing write to RISE bit 1 issued at the same edge a new rising edge on pin 1 lands → RISE[1] remains 1.
- `mem_valid` held high continuously for 6 cycles → exactly 3 `mem_ready` pulses, spaced 2 cycles apart; write with `mem_wstrb` = 4'b0010 → OUT unchanged, still acknowledged.
- `resetn` low in ACK cycle after a write of OUT = 8'hAA → `mem_ready` stays 0, `gpio_pin_out` = 0 after the reset edge.
